// File: rtl/popcount_ramp_gen.sv
// Pattern source for the popcount adder: ramps a 12-bit vector one bit per step
// until it holds the requested number of ones, in ascending or interleaved order.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | o_ready=1, vector holds last count, waiting for a request
//   S_FLUSH | mode change: clearing bits in the old order down to zero
//   S_RAMP  | stepping one bit per prescaler wrap toward the latched target
//   S_DONE  | one-cycle o_done pulse; o_ready=1 so a new request may start
module popcount_ramp_gen #(
  parameter int WIDTH_in  = 12,
  parameter int WIDTH_out = 4,
  parameter int STEP_DIV  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [WIDTH_out:0]   i_target,
  input  logic                 i_mode,
  output logic                 o_ready,
  output logic [WIDTH_in-1:0]  o_vec,
  output logic [WIDTH_out:0]   o_count,
  output logic                 o_done,
  output logic                 o_clamped
);

  localparam int CW     = WIDTH_out + 1;
  localparam int IDX_W  = (WIDTH_in > 1) ? $clog2(WIDTH_in) : 1;
  localparam int PW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int N_EVEN = (WIDTH_in + 1) / 2;

  localparam logic [CW-1:0] MAX_CNT    = CW'(WIDTH_in);
  localparam logic [PW-1:0] PRESC_LOAD = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RAMP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH_in-1:0] vec_q, vec_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       target_q, target_d;
  logic                mode_q, mode_d;
  logic                mode_new_q, mode_new_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                clamped_q, clamped_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                step;
  logic                accept;
  logic [IDX_W-1:0]    set_pos;
  logic [IDX_W-1:0]    clr_pos;

  // Position of the idx-th bit to fill; mode 1 fills evens descending, then odds ascending.
  function automatic int pos_of(input logic mode, input int idx);
    if (idx < 0 || idx >= WIDTH_in) return 0;
    if (!mode) return idx;
    if (idx < N_EVEN) return 2 * (N_EVEN - 1 - idx);
    return 2 * (idx - N_EVEN) + 1;
  endfunction

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    count_d    = count_q;
    target_d   = target_q;
    mode_d     = mode_q;
    mode_new_d = mode_new_q;
    presc_d    = presc_q;
    clamped_d  = clamped_q;

    step    = (presc_q == '0);
    accept  = i_valid && ready_q;
    set_pos = IDX_W'(pos_of(mode_q, int'(count_q)));
    clr_pos = IDX_W'(pos_of(mode_q, int'(count_q) - 1));

    if (state_q == S_FLUSH || state_q == S_RAMP)
      presc_d = step ? PRESC_LOAD : presc_q - PW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          presc_d    = PRESC_LOAD;
          mode_new_d = i_mode;
          if (i_target > MAX_CNT) begin
            target_d  = MAX_CNT;
            clamped_d = 1'b1;
          end else begin
            target_d = i_target;
          end
          if (i_mode == mode_q) begin
            state_d = S_RAMP;
          end else if (count_q != '0) begin
            state_d = S_FLUSH;
          end else begin
            mode_d  = i_mode;
            state_d = S_RAMP;
          end
        end
      end
      S_FLUSH: begin
        if (step) begin
          if (count_q != '0) begin
            vec_d[clr_pos] = 1'b0;
            count_d        = count_q - CW'(1);
          end
          // The step that empties the vector also switches to the new order.
          if (count_q <= CW'(1)) begin
            mode_d  = mode_new_q;
            state_d = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (step) begin
          if (count_q < target_q) begin
            vec_d[set_pos] = 1'b1;
            count_d        = count_q + CW'(1);
          end else if (count_q > target_q) begin
            vec_d[clr_pos] = 1'b0;
            count_d        = count_q - CW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      count_q    <= '0;
      target_q   <= '0;
      mode_q     <= 1'b0;
      mode_new_q <= 1'b0;
      presc_q    <= '0;
      clamped_q  <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      count_q    <= count_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      mode_new_q <= mode_new_d;
      presc_q    <= presc_d;
      clamped_q  <= clamped_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_vec     = vec_q;
  assign o_count   = count_q;
  assign o_done    = done_q;
  assign o_clamped = clamped_q;

endmodule

// File: tb/tb_popcount_ramp_gen.sv
// Directed bench for popcount_ramp_gen: default instance (STEP_DIV=1) plus a
// STEP_DIV=3 instance for prescaler timing and mid-ramp reset.
module tb_popcount_ramp_gen;

  logic        clk;
  logic        rst_n, rst3_n;
  logic        valid, mode, valid3, mode3;
  logic [4:0]  target, target3;
  logic        ready, done, clamped, ready3, done3, clamped3;
  logic [11:0] vec, vec3;
  logic [4:0]  count, count3;

  int n_checks = 0;
  int n_pass   = 0;

  popcount_ramp_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_target(target), .i_mode(mode),
    .o_ready(ready), .o_vec(vec), .o_count(count), .o_done(done), .o_clamped(clamped)
  );

  popcount_ramp_gen #(.WIDTH_in(12), .WIDTH_out(4), .STEP_DIV(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n), .i_valid(valid3), .i_target(target3), .i_mode(mode3),
    .o_ready(ready3), .o_vec(vec3), .o_count(count3), .o_done(done3), .o_clamped(clamped3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] t, input logic m);
    valid  = 1'b1;
    target = t;
    mode   = m;
    tick();
    valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  logic [11:0] exp_vec;
  logic [11:0] seq_a [6];
  logic [11:0] seq_b [6];
  logic [11:0] seq_f [5];
  logic [11:0] seq_3 [9];

  initial begin
    seq_a = '{12'h400, 12'h500, 12'h540, 12'h550, 12'h554, 12'h555};
    seq_b = '{12'h557, 12'h55F, 12'h57F, 12'h5FF, 12'h7FF, 12'hFFF};
    seq_f = '{12'h003, 12'h001, 12'h000, 12'h400, 12'h500};
    seq_3 = '{12'h000, 12'h000, 12'h001, 12'h001, 12'h001, 12'h003, 12'h003, 12'h003, 12'h003};

    rst_n = 1'b0; rst3_n = 1'b0;
    valid = 1'b0; target = '0; mode = 1'b0;
    valid3 = 1'b0; target3 = '0; mode3 = 1'b0;
    tick(); tick();
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();

    chk("rst_vec", 32'(vec), 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clamped", 32'(clamped), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    // Ascending fill to full.
    req(5'd12, 1'b0);
    chk("up_ready_drop", 32'(ready), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_vec = 12'((13'd1 << k) - 13'd1);
      chk("up_vec", 32'(vec), 32'(exp_vec));
      chk("up_count", 32'(count), 32'(k));
      chk("up_done_early", 32'(done), 32'd0);
    end
    tick();
    chk("up_done", 32'(done), 32'd1);
    chk("up_ready_done", 32'(ready), 32'd1);
    tick();
    chk("up_done_pulse", 32'(done), 32'd0);

    // Clear from full in reverse order.
    req(5'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_vec = 12'((13'd1 << (12 - k)) - 13'd1);
      chk("down_vec", 32'(vec), 32'(exp_vec));
      chk("down_done_early", 32'(done), 32'd0);
    end
    tick();
    chk("down_done", 32'(done), 32'd1);
    chk("down_count", 32'(count), 32'd0);
    tick();
    chk("down_done_pulse", 32'(done), 32'd0);

    // Interleaved fill to 6, then on to 12 (request issued in the DONE cycle).
    req(5'd6, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("il6_vec", 32'(vec), 32'(seq_a[k]));
    end
    tick();
    chk("il6_done", 32'(done), 32'd1);
    req(5'd12, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("il12_vec", 32'(vec), 32'(seq_b[k]));
    end
    tick();
    chk("il12_done", 32'(done), 32'd1);
    chk("il12_count", 32'(count), 32'd12);

    // Mode change to ascending: flush 12 in interleaved order, then fill 3.
    req(5'd3, 1'b0);
    wait_done("m0_3_timeout", 40);
    chk("m0_3_vec", 32'(vec), 32'h007);
    chk("m0_3_count", 32'(count), 32'd3);

    // Flush three ascending bits, then interleaved fill to 2.
    req(5'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("flush_vec", 32'(vec), 32'(seq_f[k]));
      chk("flush_done_early", 32'(done), 32'd0);
    end
    tick();
    chk("flush_done", 32'(done), 32'd1);
    chk("flush_count", 32'(count), 32'd2);

    // Over-range target is clamped; requests during ramp are ignored.
    req(5'd15, 1'b1);
    chk("clamp_flag", 32'(clamped), 32'd1);
    valid  = 1'b1;
    target = 5'd0;
    for (int k = 0; k < 10; k++) tick();
    chk("clamp_ready_busy", 32'(ready), 32'd0);
    valid = 1'b0;
    tick();
    chk("clamp_done", 32'(done), 32'd1);
    chk("clamp_vec", 32'(vec), 32'hFFF);
    chk("clamp_count", 32'(count), 32'd12);
    tick();
    chk("clamp_sticky", 32'(clamped), 32'd1);
    chk("clamp_hold_count", 32'(count), 32'd12);
    chk("clamp_idle_ready", 32'(ready), 32'd1);

    // STEP_DIV=3 instance: bit changes at cycles 3 and 6, done at 9.
    chk("sd3_clamped", 32'(clamped3), 32'd0);
    valid3 = 1'b1; target3 = 5'd2; mode3 = 1'b0;
    tick();
    valid3 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("sd3_vec", 32'(vec3), 32'(seq_3[k]));
      chk("sd3_done", 32'(done3), (k == 8) ? 32'd1 : 32'd0);
    end
    tick();
    valid3 = 1'b1; target3 = 5'd5;
    tick();
    valid3 = 1'b0;
    tick(); tick(); tick();
    chk("sd3_mid_count", 32'(count3), 32'd3);
    rst3_n = 1'b0;
    #1;
    chk("sd3_rst_vec", 32'(vec3), 32'h0);
    chk("sd3_rst_count", 32'(count3), 32'd0);
    chk("sd3_rst_ready", 32'(ready3), 32'd1);
    chk("sd3_rst_done", 32'(done3), 32'd0);
    tick();
    rst3_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("sd3_post_done", 32'(done3), 32'd0);
      chk("sd3_post_vec", 32'(vec3), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/popcount_ramp_gen.md
Name: popcount_ramp_gen

Overview:
- Inverse of the team's 12-input popcount adder: accepts a target ones-count and drives a 12-bit vector that contains exactly that many ones.
- The vector ramps one bit per step toward the target, so the popcount adder downstream sees a monotonic count sequence.
- Used as a self-checking stimulus/pattern source: its o_vec feeds the adder's i_a, and its o_count is the expected adder o_sum.

Parameters:
- WIDTH_in, 12, width of generated vector o_vec.
- WIDTH_out, 4, count width; count ports are WIDTH_out+1 bits.
- STEP_DIV, 1, clock cycles per ramp step (>=1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  request valid.
- i_target  input  WIDTH_out+1  requested ones-count.
- i_mode  input  1  fill order: 0 = ascending, 1 = interleaved.
- o_ready  output  1  block idle, request can be accepted.
- o_vec  output  WIDTH_in  generated vector.
- o_count  output  WIDTH_out+1  number of ones currently in o_vec.
- o_done  output  1  one-cycle pulse when the target is reached.
- o_clamped  output  1  sticky; set when a target > WIDTH_in was clamped.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_vec=0, o_count=0, o_done=0, o_clamped=0, o_ready=1.
  - State=IDLE, current mode=0, prescaler=0.
  - Reset mid-ramp aborts immediately; no o_done pulse.
- Fill order is a position list P[0..WIDTH_in-1]:
  - Mode 0: P = 0,1,2,...,11.
  - Mode 1: P = 10,8,6,4,2,0,1,3,5,7,9,11 (evens descending, then odds ascending).
- Invariant: o_vec = OR of bits P[0..o_count-1] for the current mode; popcount(o_vec) == o_count at all times.
- Handshake:
  - A request is accepted on a rising edge where i_valid && o_ready.
  - i_target and i_mode are latched at acceptance; o_ready drops the next cycle.
  - i_valid while o_ready=0 is ignored.
- Clamp: if i_target > WIDTH_in, the latched target is WIDTH_in and o_clamped is set (cleared only by reset).
- States:
  - IDLE: o_ready=1. On accept:
    - latched mode == current mode → RAMP.
    - latched mode differs and o_count>0 → FLUSH.
    - latched mode differs and o_count==0 → adopt new mode, go to RAMP.
  - FLUSH: steps down to 0 in the old order, one bit per step. At o_count==0, adopt the new mode and go to RAMP.
  - RAMP, each step:
    - o_count < target: set bit P[o_count], o_count+1.
    - o_count > target: clear bit P[o_count-1], o_count-1.
    - o_count == target: go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_ready=1 in that same cycle, then IDLE. A request accepted in the DONE cycle is processed exactly as from IDLE.
- Step timing:
  - A prescaler counts STEP_DIV cycles; one step occurs per prescaler wrap.
  - The prescaler restarts at acceptance; the first step occurs STEP_DIV cycles after the accept edge.
  - Entering DONE costs one extra step slot after the final bit change.
  - Latency accept→o_done = (|target − count| + 1) × STEP_DIV cycles, plus flush steps when the mode changes.
- Target equal to current count, same mode: no vector change, o_done after STEP_DIV cycles.
- Boundaries:
  - Count never exceeds WIDTH_in and never underflows below 0.
  - Target 0 from full clears all bits in reverse P order.
- All outputs are registered; no combinational path from inputs to outputs except none (o_ready is state-decoded).

Test Plan:
- Reset, then request target=12 mode=0 → o_vec steps 0x001,0x003,...,0xFFF one per cycle; o_count 1..12; o_done at cycle 13 after accept; o_ready=1 with o_done.
- From 0xFFF, request target=0 mode=0 → bits clear 11 down to 0; final o_vec=0x000, o_count=0, single o_done pulse.
- Request target=6 mode=1 from 0 → o_vec 0x400,0x500,0x540,0x550,0x554,0x555; then target=12 mode=1 → 0x557,0x55F,...,0xFFF.
- With o_vec=0x007 (mode 0, count 3), request target=2 mode=1 → flush to 0 in three steps, then 0x400,0x500; o_count=2; o_done once.
- Request target=15 → ramps to 0xFFF, o_count=12, o_clamped=1 and stays 1; i_valid held during ramp is ignored.
- STEP_DIV=3: target=2 from 0 → changes at cycles 3 and 6, o_done at cycle 9; assert i_rst_n=0 mid-ramp → all outputs 0 immediately, o_ready=1, no o_done.
